// File: rtl/fetch_decode_buffer_if.sv
// rtl/fetch_decode_buffer_if.sv - I-cache fetch port and decoded instruction-queue port bundle
interface fetch_decode_buffer_if;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        iq_valid;
  logic        iq_ack;
  logic [31:0] iq_pc;
  logic [3:0]  iq_op;
  logic [31:0] iq_imm;
  logic        iq_imm_valid;
  logic [4:0]  iq_rs1;
  logic [4:0]  iq_rs2;
  logic [4:0]  iq_rd;
  logic [2:0]  iq_funct3;
  logic        iq_funct7b;

  modport master (
    output instr_read, instr_mem_address,
    input  instr_mem_resp, instr_mem_rdata,
    output iq_valid,
    input  iq_ack,
    output iq_pc, iq_op, iq_imm, iq_imm_valid, iq_rs1, iq_rs2, iq_rd, iq_funct3, iq_funct7b
  );

  modport slave (
    input  instr_read, instr_mem_address,
    output instr_mem_resp, instr_mem_rdata,
    input  iq_valid,
    output iq_ack,
    input  iq_pc, iq_op, iq_imm, iq_imm_valid, iq_rs1, iq_rs2, iq_rd, iq_funct3, iq_funct7b
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - sequential prefetch FIFO with redirect/squash and head-entry decode
module fetch_decode_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  fetch_decode_buffer_if.master    bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [3:0] OP_ARITH   = 4'd0;
  localparam logic [3:0] OP_LUI     = 4'd1;
  localparam logic [3:0] OP_AUIPC   = 4'd2;
  localparam logic [3:0] OP_JAL     = 4'd3;
  localparam logic [3:0] OP_JALR    = 4'd4;
  localparam logic [3:0] OP_BRANCH  = 4'd5;
  localparam logic [3:0] OP_LD      = 4'd6;
  localparam logic [3:0] OP_ST      = 4'd7;
  localparam logic [3:0] OP_CSR     = 4'd8;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   squash_addr;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic          push, pop, flush;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    flush         = 1'b0;
    pop           = (count != '0) && bus.iq_ack && !redirect;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_pc;
        end else if (count < FULL) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_pc;
          state_next    = bus.instr_mem_resp ? IDLE : SQUASH;
        end else if (bus.instr_mem_resp) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = ((count + CW'(1) - CW'(pop)) < FULL) ? FETCH : IDLE;
        end
      end
      SQUASH: begin
        // The outstanding read still belongs to the old stream; its data is thrown away.
        if (redirect) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_pc;
        end
        if (bus.instr_mem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    count_next = flush ? '0 : (count + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      squash_addr <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (state == FETCH && redirect && !bus.instr_mem_resp) begin
        squash_addr <= fetch_pc;
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= bus.instr_mem_rdata;
    end
  end

  assign bus.instr_read        = (state != IDLE);
  assign bus.instr_mem_address = (state == SQUASH) ? squash_addr : fetch_pc;
  assign occupancy             = count;
  assign bus.iq_valid          = (count != '0);

  logic [31:0] head_instr;
  assign head_instr     = instr_mem[head];
  assign bus.iq_pc      = pc_mem[head];
  assign bus.iq_rs1     = head_instr[19:15];
  assign bus.iq_rs2     = head_instr[24:20];
  assign bus.iq_rd      = head_instr[11:7];
  assign bus.iq_funct3  = head_instr[14:12];
  assign bus.iq_funct7b = head_instr[30];

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                  head_instr[30:25], head_instr[11:8], 1'b0};
  assign imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                  head_instr[20], head_instr[30:21], 1'b0};
  assign imm_u = {head_instr[31:12], 12'h000};

  always_comb begin
    bus.iq_op        = OP_ILLEGAL;
    bus.iq_imm       = '0;
    bus.iq_imm_valid = 1'b0;
    case (head_instr[6:0])
      7'b0110111: begin bus.iq_op = OP_LUI;    bus.iq_imm = imm_u; bus.iq_imm_valid = 1'b1; end
      7'b0010111: begin bus.iq_op = OP_AUIPC;  bus.iq_imm = imm_u; bus.iq_imm_valid = 1'b1; end
      7'b1101111: begin bus.iq_op = OP_JAL;    bus.iq_imm = imm_j; bus.iq_imm_valid = 1'b1; end
      7'b1100111: begin bus.iq_op = OP_JALR;   bus.iq_imm = imm_i; bus.iq_imm_valid = 1'b1; end
      7'b1100011: begin bus.iq_op = OP_BRANCH; bus.iq_imm = imm_b; bus.iq_imm_valid = 1'b1; end
      7'b0000011: begin bus.iq_op = OP_LD;     bus.iq_imm = imm_i; bus.iq_imm_valid = 1'b1; end
      7'b0100011: begin bus.iq_op = OP_ST;     bus.iq_imm = imm_s; bus.iq_imm_valid = 1'b1; end
      7'b1110011: begin bus.iq_op = OP_CSR;    bus.iq_imm = imm_i; bus.iq_imm_valid = 1'b1; end
      7'b0010011: begin bus.iq_op = OP_ARITH;  bus.iq_imm = imm_i; bus.iq_imm_valid = 1'b1; end
      7'b0110011: begin bus.iq_op = OP_ARITH; end
      default: ;
    endcase
  end
endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Parametrised successor to the single-entry fetch/decode register.
- Owns its own fetch PC and prefetches sequential instructions from the I-cache into a DEPTH-entry FIFO.
- Decodes the head entry into control-word fields for the instruction queue.
- Supports redirect (flush plus new PC) with squashing of an in-flight fetch.

Parameters:
- DEPTH, 4, number of prefetch buffer entries (power of two, ≥2).
- RESET_PC, 32'h0000_0060, fetch PC loaded on reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- instr_read  output  1  I-cache read request
- instr_mem_address  output  32  fetch address (fetch_pc register)
- instr_mem_resp  input  1  I-cache response strobe
- instr_mem_rdata  input  32  fetched instruction
- redirect  input  1  flush buffer and restart fetch
- redirect_pc  input  32  new fetch PC, valid with redirect
- iq_valid  output  1  head entry decoded and offered
- iq_ack  input  1  IQ accepts head this cycle
- iq_pc  output  32  PC of head instruction
- iq_op  output  4  0 ARITH, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LD, 7 ST, 8 CSR, 15 ILLEGAL
- iq_imm  output  32  decoded immediate (src2 data)
- iq_imm_valid  output  1  immediate used as src2
- iq_rs1, iq_rs2, iq_rd  output  5 each  register fields
- iq_funct3  output  3  instr[14:12]
- iq_funct7b  output  1  instr[30]
- occupancy  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst==0 at posedge): fetch_pc=RESET_PC, head/tail/count=0, state IDLE.
  - Outputs after reset: instr_read=0, iq_valid=0, occupancy=0.
  - Reset mid-fetch abandons the request; no squash is tracked.
- Fetch FSM has three states: IDLE, FETCH, SQUASH.
  - instr_read=1 in FETCH and SQUASH.
  - Address is held stable until instr_mem_resp.
- IDLE:
  - redirect: fetch_pc<=redirect_pc, buffer cleared, stay IDLE.
  - else if count<DEPTH: go to FETCH.
- FETCH, instr_mem_resp without redirect:
  - Push {fetch_pc, rdata} at tail, fetch_pc+=4 (mod 2^32).
  - Stay in FETCH if count_next<DEPTH, else go to IDLE.
- FETCH, redirect without resp: clear buffer, fetch_pc<=redirect_pc, go to SQUASH.
- FETCH, redirect with resp in the same cycle: response dropped, buffer cleared, fetch_pc<=redirect_pc, go to IDLE.
- SQUASH:
  - Hold instr_read and the old address until resp; discard data; go to IDLE.
  - A further redirect in SQUASH updates fetch_pc only.
- A fetch is issued only when count<DEPTH, so a response always has space. The FIFO never overflows.
- Latency:
  - From reset release: IDLE 1 cycle, then instr_read.
  - Response at cycle k gives iq_valid at k+1. There is no combinational rdata→iq path.
- Output handshake:
  - iq_valid = (count!=0).
  - Pop when iq_valid && iq_ack && !redirect. head wraps modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - redirect overrides pop and push; count<=0.
- Decode is purely combinational from the head entry, per opcode. Default is ILLEGAL, imm=0, imm_valid=0.
  - LUI/AUIPC: imm={i[31:12],12'h0}.
  - JAL: J-imm.
  - BRANCH: B-imm.
  - ST: S-imm.
  - op_imm (ARITH), JALR, LD, CSR: I-imm.
  - op_reg: ARITH, imm_valid=0.
  - imm_valid=1 for all the above except op_reg and ILLEGAL.
- Field outputs (rs1/rs2/rd/funct3/funct7b) are driven from the head entry regardless of iq_valid. When empty they reflect the stale head and are don't-care.

Test Plan:
- Release reset, I-cache resp 2 cycles after each read, iq_ack=0 → addresses 0x60,0x64,0x68,0x6C fetched; occupancy reaches 4; instr_read stays 0 afterwards.
- Full buffer, iq_ack=1 for one cycle → iq_pc 0x60 popped; next fetch 0x70 issued; on its response occupancy returns to 4.
- Redirect to 0x200 while a read to 0x70 is pending (resp 3 cycles later) → rdata dropped, occupancy=0, next read address 0x200; first iq_pc=0x200.
- Redirect coincident with instr_mem_resp → that data never appears; next cycle IDLE; read 0x200 the cycle after.
- Decode instr 0xFE010113 (addi sp,sp,-32) → op ARITH, imm 0xFFFFFFE0, rd=2, rs1=2. 0x00C0006F (jal x0,12) → op JAL, imm 0x0000000C. 0x00000000 → ILLEGAL, imm_valid=0.
- Assert rst=0 with 3 entries held and a read pending → next cycle occupancy=0, iq_valid=0, instr_read=0, address 0x60.
